// File: rtl/ring_cntr_pkg.sv
// Shared types and helpers for the ring counter generator.
//   rc_mode_t : simple one-hot ring or twisted (Johnson) ring
//   rc_dir_t  : shift toward MSB (RC_UP) or toward LSB (RC_DN)
//   rc_seed   : the state a ring of the given mode wraps back to
package ring_cntr_pkg;

  typedef enum logic {RC_SIMPLE = 1'b0, RC_TWIST = 1'b1} rc_mode_t;
  typedef enum logic {RC_UP = 1'b0, RC_DN = 1'b1} rc_dir_t;

  // Widest counter the seed helper can describe; callers size-cast the result.
  localparam int unsigned RC_MAX_W = 64;

  // Simple ring seeds at 0...01, twisted ring seeds at all zeros.
  function automatic logic [RC_MAX_W-1:0] rc_seed(input rc_mode_t mode,
                                                   input int unsigned n);
    logic [RC_MAX_W-1:0] s;
    s = '0;
    if (mode == RC_SIMPLE && n >= 1) s[0] = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/ring_cntr_chk.sv
// Combinational legality check and binary phase decode of an N-bit ring
// state, interpreted according to the supplied mode.
//   val   : ring state to examine
//   mode  : RC_SIMPLE (exactly one bit set) or RC_TWIST (at most one
//           transition between adjacent bits)
//   legal : high when val is a reachable state for mode
//   phase : index of val within the ring sequence
module ring_cntr_chk
  import ring_cntr_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = $clog2(2 * N)
) (
  input  logic [N-1:0]  val,
  input  rc_mode_t      mode,
  output logic          legal,
  output logic [PW-1:0] phase
);

  int ones;
  int trans;
  int idx;

  always_comb begin
    ones  = 0;
    trans = 0;
    idx   = 0;
    legal = 1'b0;
    phase = '0;

    for (int i = 0; i < N; i++) begin
      if (val[i]) begin
        ones = ones + 1;
        idx  = i;
      end
    end
    for (int i = 0; i < N - 1; i++) begin
      if (val[i] != val[i+1]) trans = trans + 1;
    end

    if (mode == RC_SIMPLE) begin
      legal = (ones == 1);
      phase = PW'(idx);
    end else begin
      legal = (trans <= 1);
      // Johnson sequence fills ones from the LSB for the first half, then
      // drains them from the LSB for the second half.
      if (val == '0)   phase = '0;
      else if (val[0]) phase = PW'(ones);
      else             phase = PW'(2 * N - ones);
    end
  end

endmodule

// File: rtl/ring_cntr_gen.sv
// Runtime-configurable N-bit ring counter used as a multi-phase sequencer.
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   en       : advance one state per clock
//   mode     : 0 simple ring (N states), 1 twisted ring (2N states)
//   dir      : 0 shift toward MSB, 1 shift toward LSB
//   load     : parallel load request (independent of en)
//   load_val : value to load; illegal values fall back to the seed
//   cnt      : registered counter state
//   phase    : binary index of cnt, combinational
//   tc       : one-cycle pulse when a step lands on the seed
//   err      : one-cycle pulse on an illegal load or an upset state
module ring_cntr_gen
  import ring_cntr_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = $clog2(2 * N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          mode,
  input  logic          dir,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  cnt,
  output logic [PW-1:0] phase,
  output logic          tc,
  output logic          err
);

  rc_mode_t     mode_in;
  rc_dir_t      dir_in;
  rc_mode_t     mode_q;
  rc_mode_t     mode_nxt;
  logic [N-1:0] cnt_q;
  logic [N-1:0] cnt_nxt;
  logic [N-1:0] stepped;
  logic [N-1:0] seed_cur;
  logic [N-1:0] seed_new;
  logic         tc_q;
  logic         tc_nxt;
  logic         err_q;
  logic         err_nxt;
  logic         cnt_legal;
  logic         ld_legal;
  logic [PW-1:0] ld_phase;

  assign mode_in  = rc_mode_t'(mode);
  assign dir_in   = rc_dir_t'(dir);
  assign seed_cur = N'(rc_seed(mode_q, N));
  assign seed_new = N'(rc_seed(mode_in, N));

  // Both the live state and the load candidate are judged against the
  // registered mode: a mode change always wins priority, so any load that
  // gets evaluated sees mode == mode_q.
  ring_cntr_chk #(.N(N), .PW(PW)) u_chk_cnt (
    .val   (cnt_q),
    .mode  (mode_q),
    .legal (cnt_legal),
    .phase (phase)
  );

  ring_cntr_chk #(.N(N), .PW(PW)) u_chk_load (
    .val   (load_val),
    .mode  (mode_q),
    .legal (ld_legal),
    .phase (ld_phase)
  );

  always_comb begin
    stepped = cnt_q;
    unique case ({mode_q, dir_in})
      {RC_SIMPLE, RC_UP}: stepped = {cnt_q[N-2:0], cnt_q[N-1]};
      {RC_SIMPLE, RC_DN}: stepped = {cnt_q[0], cnt_q[N-1:1]};
      {RC_TWIST,  RC_UP}: stepped = {cnt_q[N-2:0], ~cnt_q[N-1]};
      {RC_TWIST,  RC_DN}: stepped = {~cnt_q[0], cnt_q[N-1:1]};
      default:            stepped = cnt_q;
    endcase
  end

  always_comb begin
    cnt_nxt  = cnt_q;
    mode_nxt = mode_q;
    tc_nxt   = 1'b0;
    err_nxt  = 1'b0;

    if (mode_in != mode_q) begin
      cnt_nxt  = seed_new;
      mode_nxt = mode_in;
    end else if (load) begin
      if (ld_legal) begin
        cnt_nxt = load_val;
      end else begin
        cnt_nxt = seed_cur;
        err_nxt = 1'b1;
      end
    end else if (!cnt_legal) begin
      // Upset recovery takes effect even while the counter is paused.
      cnt_nxt = seed_cur;
      err_nxt = 1'b1;
    end else if (en) begin
      cnt_nxt = stepped;
      tc_nxt  = (stepped == seed_cur);
    end
  end

  // State register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= N'(rc_seed(RC_SIMPLE, N));
      mode_q <= RC_SIMPLE;
      tc_q   <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_nxt;
      mode_q <= mode_nxt;
      tc_q   <= tc_nxt;
      err_q  <= err_nxt;
    end
  end

  assign cnt = cnt_q;
  assign tc  = tc_q;
  assign err = err_q;

endmodule

// File: tb/tb_ring_cntr_gen.sv
module tb_ring_cntr_gen;

  localparam int N  = 4;
  localparam int PW = $clog2(2 * N);

  logic          clk;
  logic          rst;
  logic          en;
  logic          mode;
  logic          dir;
  logic          load;
  logic [N-1:0]  load_val;
  logic [N-1:0]  cnt;
  logic [PW-1:0] phase;
  logic          tc;
  logic          err;

  int errors;
  int checks;

  ring_cntr_gen #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .cnt      (cnt),
    .phase    (phase),
    .tc       (tc),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
    step(); step();
    checks++; if (cnt !== 4'b0001) begin errors++; $display("FAIL reset_cnt got=%b exp=0001", cnt); end
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase got=%0d exp=0", phase); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc got=%b exp=0", tc); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
    rst = 1'b1;
    step();
    checks++; if (cnt !== 4'b0001) begin errors++; $display("FAIL reset_hold_cnt got=%b exp=0001", cnt); end
  endtask

  task automatic test_simple_ring();
    logic [3:0] exp_cnt [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [2:0] exp_ph  [4] = '{3'd1, 3'd2, 3'd3, 3'd0};
    mode = 1'b0; dir = 1'b0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (cnt !== exp_cnt[i]) begin errors++; $display("FAIL simple_cnt[%0d] got=%b exp=%b", i, cnt, exp_cnt[i]); end
      checks++; if (phase !== exp_ph[i]) begin errors++; $display("FAIL simple_phase[%0d] got=%0d exp=%0d", i, phase, exp_ph[i]); end
      checks++; if (tc !== (i == 3)) begin errors++; $display("FAIL simple_tc[%0d] got=%b exp=%b", i, tc, (i == 3)); end
    end
  endtask

  task automatic test_twisted_ring();
    logic [3:0] exp_cnt [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [2:0] exp_ph  [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    mode = 1'b1; dir = 1'b0; en = 1'b1;
    step();
    checks++; if (cnt !== 4'b0000) begin errors++; $display("FAIL twist_reinit_cnt got=%b exp=0000", cnt); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL twist_reinit_tc got=%b exp=0", tc); end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (cnt !== exp_cnt[i]) begin errors++; $display("FAIL twist_cnt[%0d] got=%b exp=%b", i, cnt, exp_cnt[i]); end
      checks++; if (phase !== exp_ph[i]) begin errors++; $display("FAIL twist_phase[%0d] got=%0d exp=%0d", i, phase, exp_ph[i]); end
      checks++; if (tc !== (i == 7)) begin errors++; $display("FAIL twist_tc[%0d] got=%b exp=%b", i, tc, (i == 7)); end
    end
  endtask

  task automatic test_twisted_down();
    logic [3:0] exp_cnt [5] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111};
    logic [2:0] exp_ph  [5] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3};
    mode = 1'b1; dir = 1'b1; en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (cnt !== exp_cnt[i]) begin errors++; $display("FAIL down_cnt[%0d] got=%b exp=%b", i, cnt, exp_cnt[i]); end
      checks++; if (phase !== exp_ph[i]) begin errors++; $display("FAIL down_phase[%0d] got=%0d exp=%0d", i, phase, exp_ph[i]); end
      checks++; if (tc !== 1'b0) begin errors++; $display("FAIL down_tc[%0d] got=%b exp=0", i, tc); end
    end
    en = 1'b0; dir = 1'b0;
  endtask

  task automatic test_load();
    mode = 1'b1; en = 1'b0;
    load = 1'b1; load_val = 4'b0111;
    step();
    checks++; if (cnt !== 4'b0111) begin errors++; $display("FAIL load_ok_cnt got=%b exp=0111", cnt); end
    checks++; if (phase !== 3'd3) begin errors++; $display("FAIL load_ok_phase got=%0d exp=3", phase); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL load_ok_err got=%b exp=0", err); end
    load_val = 4'b0110;
    step();
    checks++; if (cnt !== 4'b0000) begin errors++; $display("FAIL load_bad_twist_cnt got=%b exp=0000", cnt); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL load_bad_twist_err got=%b exp=1", err); end
    load = 1'b0;
    step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL load_err_pulse got=%b exp=0", err); end
    mode = 1'b0;
    step();
    checks++; if (cnt !== 4'b0001) begin errors++; $display("FAIL mode0_reinit_cnt got=%b exp=0001", cnt); end
    load = 1'b1; load_val = 4'b0101;
    step();
    checks++; if (cnt !== 4'b0001) begin errors++; $display("FAIL load_bad_simple_cnt got=%b exp=0001", cnt); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL load_bad_simple_err got=%b exp=1", err); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL load_bad_simple_tc got=%b exp=0", tc); end
    load = 1'b0;
  endtask

  task automatic test_hold_upset();
    mode = 1'b0; dir = 1'b0; en = 1'b1;
    step(); step();
    checks++; if (cnt !== 4'b0100) begin errors++; $display("FAIL pre_hold_cnt got=%b exp=0100", cnt); end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (cnt !== 4'b0100) begin errors++; $display("FAIL hold_cnt[%0d] got=%b exp=0100", i, cnt); end
      checks++; if (tc !== 1'b0) begin errors++; $display("FAIL hold_tc[%0d] got=%b exp=0", i, tc); end
    end
    force dut.cnt_q = 4'b0110;
    #1;
    release dut.cnt_q;
    step();
    checks++; if (cnt !== 4'b0001) begin errors++; $display("FAIL upset_cnt got=%b exp=0001", cnt); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL upset_err got=%b exp=1", err); end
    step();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL upset_err_pulse got=%b exp=0", err); end
  endtask

  task automatic test_async_reset();
    mode = 1'b0; dir = 1'b0; en = 1'b1;
    step(); step(); step();
    checks++; if (cnt !== 4'b1000) begin errors++; $display("FAIL pre_areset_cnt got=%b exp=1000", cnt); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (cnt !== 4'b0001) begin errors++; $display("FAIL areset_cnt got=%b exp=0001", cnt); end
    checks++; if (phase !== 3'd0) begin errors++; $display("FAIL areset_phase got=%0d exp=0", phase); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL areset_tc got=%b exp=0", tc); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL areset_err got=%b exp=0", err); end
    #1;
    rst = 1'b1;
    step();
    checks++; if (cnt !== 4'b0010) begin errors++; $display("FAIL resume_cnt got=%b exp=0010", cnt); end
    en = 1'b0;
  endtask

  task automatic test_mode_through_reset();
    rst = 1'b0; mode = 1'b1; en = 1'b1;
    step();
    checks++; if (cnt !== 4'b0001) begin errors++; $display("FAIL mreset_cnt got=%b exp=0001", cnt); end
    rst = 1'b1;
    step();
    checks++; if (cnt !== 4'b0000) begin errors++; $display("FAIL mreset_reinit_cnt got=%b exp=0000", cnt); end
    checks++; if (tc !== 1'b0) begin errors++; $display("FAIL mreset_reinit_tc got=%b exp=0", tc); end
    step();
    checks++; if (cnt !== 4'b0001) begin errors++; $display("FAIL mreset_first_step got=%b exp=0001", cnt); end
    en = 1'b0; mode = 1'b0;
    step();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_simple_ring();
    test_twisted_ring();
    test_twisted_down();
    test_load();
    test_hold_upset();
    test_async_reset();
    test_mode_through_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
